msg_fifo_arbiter: RTL

MSG_FIFO_ARBITER -- requirements
Module: msg_fifo_arbiter

---
 rtl/msg_arb_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/msg_fifo_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/msg_arb_pkg.sv
// Shared types and defaults for the message FIFO arbiter.
// Pure definitions: no logic, no latency, no backpressure.
// Header word layout: {tag, requester index, frame counter}.
package msg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_HDR  = 2'd2,
        ST_XFER = 2'd3
    } state_t;

    localparam logic [7:0] HDR_TAG           = 8'hA5;
    localparam int         DEF_NUM_REQ       = 4;
    localparam int         DEF_FIFO_DEPTH    = 256;
    localparam int         DEF_MAX_MSG_WORDS = 4;

`ifdef MSG_ARB_HEADER_EN
    localparam int HDR_WORDS = 1;
`else
    localparam int HDR_WORDS = 0;
`endif

    function automatic logic [31:0] hdr_word(input logic [7:0] idx, input logic [15:0] frame);
        return {HDR_TAG, idx, frame};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: one-hot grant to the first requester at or after ptr.
// Latency: combinational. Backpressure: none; grant is a pure function of req/ptr.
// No grant bit is set when req is all zero.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic          found;
    logic [PW-1:0] j;

    always_comb begin
        grant = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = PW'((int'(ptr) + k) % N);
            if (!found && req[j]) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/msg_fifo_arbiter.sv
// Arbitrates whole messages from NUM_REQ requesters into one downstream FIFO; MSG_ARB_HEADER_EN adds a header word.
// Latency: req_ack to fifo_wrreq is one cycle; grant needs IDLE->ARB->(HDR)->XFER.
// Backpressure: no grant until the FIFO has room for a full message; a dropped req stalls XFER.
module msg_fifo_arbiter
    import msg_arb_pkg::*;
#(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int MAX_MSG_WORDS = DEF_MAX_MSG_WORDS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_last,
    input  logic [NUM_REQ*32-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ack,
    input  logic [7:0]            fifo_usedw,
    input  logic                  fifo_flush,
    input  logic                  frame_eop,
    output logic [31:0]           fifo_data,
    output logic                  fifo_wrreq,
    output logic                  busy,
    output logic [7:0]            overflow_cnt,
    output logic [15:0]           frame_cnt
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_MSG_WORDS + 1);

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic [NUM_REQ-1:0] arb_gnt, ack;
    logic [PW-1:0]   arb_idx, ptr_next;
    logic            room, cur_req, cur_last, cap, ovf_inc;
    logic            wr_vld_d;
    logic [31:0]     wr_dat_d, cur_dat;

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
        .req   (req),
        .ptr   (ptr_q),
        .grant (arb_gnt)
    );

    always_comb begin
        arb_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_gnt[k]) arb_idx = PW'(k);
        end
    end

    // Room for the longest possible message, plus its header when enabled.
    assign room     = (32'(fifo_usedw) + 32'(MAX_MSG_WORDS) + 32'(HDR_WORDS)) <= 32'(FIFO_DEPTH);
    assign cur_req  = req[gnt_q];
    assign cur_last = req_last[gnt_q];
    assign cur_dat  = req_data[32*gnt_q +: 32];
    assign cap      = (wcnt_q == CW'(MAX_MSG_WORDS - 1));
    assign ptr_next = (gnt_q == PW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        wcnt_d   = wcnt_q;
        ovf_inc  = 1'b0;
        wr_vld_d = 1'b0;
        wr_dat_d = fifo_data;
        ack      = '0;
        case (state_q)
            ST_IDLE: begin
                if (|req) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (!(|req)) begin
                    state_d = ST_IDLE;
                end else if (room) begin
                    gnt_d  = arb_idx;
                    wcnt_d = '0;
`ifdef MSG_ARB_HEADER_EN
                    state_d = ST_HDR;
`else
                    state_d = ST_XFER;
`endif
                end
            end
            ST_HDR: begin
`ifdef MSG_ARB_HEADER_EN
                wr_vld_d = 1'b1;
                wr_dat_d = hdr_word(8'(gnt_q), frame_cnt);
                state_d  = ST_XFER;
`else
                state_d  = ST_IDLE;
`endif
            end
            ST_XFER: begin
                if (cur_req) begin
                    ack[gnt_q] = 1'b1;
                    wr_vld_d   = 1'b1;
                    wr_dat_d   = cur_dat;
                    wcnt_d     = wcnt_q + 1'b1;
                    // Hitting the word cap closes the message even without req_last.
                    if (cur_last || cap) begin
                        state_d = ST_IDLE;
                        ptr_d   = ptr_next;
                        ovf_inc = !cur_last;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (fifo_flush) begin
            state_d  = ST_IDLE;
            ptr_d    = ptr_q;
            ack      = '0;
            wr_vld_d = 1'b0;
            wr_dat_d = fifo_data;
            ovf_inc  = 1'b0;
        end
    end

    assign req_ack = reset ? '0 : ack;
    assign busy    = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            gnt_q        <= '0;
            wcnt_q       <= '0;
            overflow_cnt <= '0;
            frame_cnt    <= '0;
            fifo_wrreq   <= 1'b0;
            fifo_data    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            wcnt_q     <= wcnt_d;
            fifo_wrreq <= wr_vld_d;
            fifo_data  <= wr_dat_d;
            if (ovf_inc && overflow_cnt != 8'hFF) overflow_cnt <= overflow_cnt + 1'b1;
            if (frame_eop) frame_cnt <= frame_cnt + 1'b1;
        end
    end

endmodule
